// File: rtl/design_c_pkg.sv
// -----------------------------------------------------------------------------
// design_c_pkg
// Shared constants and helpers for the block C hub family.
//
// Contents:
//   NUM_CH_DEF, DW_DEF, DEPTH_DEF : default hub parameters
//   MAX_CH                        : largest channel count any hub variant uses
//   rr_next(req, last, n)         : round-robin search helper. It returns the
//                                   index of the first requesting channel after
//                                   'last' (wrapping modulo n), or -1 if no
//                                   channel is requesting.
// -----------------------------------------------------------------------------
package design_c_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DW_DEF     = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int MAX_CH     = 16;

    // The loop walks from the farthest candidate (last+n) toward the nearest
    // (last+1). A later hit overwrites an earlier one, so the nearest
    // requester after 'last' wins. The loop bound is constant, which keeps
    // the function synthesizable for any n up to MAX_CH.
    function automatic int rr_next(input logic [MAX_CH-1:0] req,
                                   input int                last,
                                   input int                n);
        int         res;
        int         idx;
        logic [3:0] sel;
        res = -1;
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= n) begin
                idx = (last + k) % n;
                sel = idx[3:0];
                if (req[sel]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/design_c_rr_arb.sv
// -----------------------------------------------------------------------------
// design_c_rr_arb
// Purely combinational round-robin arbiter over N requesters.
//
// Ports:
//   i_req          N   request vector (already qualified by the caller)
//   i_last_grant   CW  index of the most recently granted requester
//   o_grant        N   one-hot grant, or all zero when nobody requests
//   o_grant_idx    CW  index of the granted requester (valid with o_grant_valid)
//   o_grant_valid  1   a grant was issued this cycle
// -----------------------------------------------------------------------------
module design_c_rr_arb
    import design_c_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [CW-1:0] i_last_grant,
    output logic [N-1:0]  o_grant,
    output logic [CW-1:0] o_grant_idx,
    output logic          o_grant_valid
);

    logic [MAX_CH-1:0] w_req_ext;
    int                w_idx;

    assign w_req_ext = MAX_CH'(i_req);

    always_comb begin
        w_idx = rr_next(w_req_ext, int'(i_last_grant), N);
    end

    // A negative index from rr_next means no requester. The truncated index
    // is then meaningless, so the one-hot vector is forced to zero.
    assign o_grant_valid = (w_idx >= 0);
    assign o_grant_idx   = CW'(w_idx);
    assign o_grant       = o_grant_valid ? (N'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/design_c_hub.sv
// -----------------------------------------------------------------------------
// design_c_hub
// Collects NUM_CH source channels into one tagged stream. A fair round-robin
// arbiter feeds an inline first-word-fall-through FIFO. The test-control pad
// is modelled as a registered out/oe pair, and the inout itself is resolved
// at the pad ring.
//
// Ports:
//   clk         1            block clock, rising edge
//   rst         1            synchronous active-high reset
//   capture_en  1            enables granting of input channels
//   in_valid    NUM_CH       per-channel valid
//   in_data     NUM_CH*DW    channel i on bits [i*DW +: DW]
//   in_ready    NUM_CH       one-hot-or-zero grant
//   out_valid   1            FIFO non-empty
//   out_data    DW           head entry data
//   out_ch      CW           head entry source channel
//   out_ready   1            downstream accepts the head entry
//   fifo_level  AW+1         current occupancy, 0..DEPTH
//   tc_in       1            test-control input
//   tc_out      1            tc_in delayed by two flops
//   tc_oe       1            capture_en delayed by one flop
// -----------------------------------------------------------------------------
module design_c_hub
    import design_c_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEF,
    parameter  int DW     = DW_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CW     = $clog2(NUM_CH),
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture_en,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*DW-1:0] in_data,
    output logic [NUM_CH-1:0]    in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready,
    output logic [AW:0]          fifo_level,
    input  logic                 tc_in,
    output logic                 tc_out,
    output logic                 tc_oe
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [CW-1:0]     r_last_grant;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [DW-1:0]     r_mem_data [DEPTH];
    logic [CW-1:0]     r_mem_ch   [DEPTH];
    logic              r_tc_d1;
    logic              r_tc_d2;
    logic              r_tc_oe;

    logic              w_can_grant;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_grant;
    logic [CW-1:0]     w_grant_idx;
    logic              w_grant_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;
    logic [DW-1:0]     w_push_data;

    // Granting is gated only by our own occupancy, never by out_ready. A full
    // FIFO therefore refuses a new word even in a cycle where the head is
    // being popped, which keeps in_ready free of any combinational path from
    // downstream.
    assign w_can_grant = capture_en & ~rst & (r_level != FULL_LEVEL);
    assign w_req       = in_valid & {NUM_CH{w_can_grant}};

    design_c_rr_arb #(
        .N (NUM_CH)
    ) u_arb (
        .i_req         (w_req),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // The arbiter only sees qualified requests, so any grant is also an
    // accepted transfer.
    assign in_ready    = w_grant;
    assign w_push      = w_grant_valid;
    assign w_not_empty = (r_level != '0);
    assign w_pop       = w_not_empty & out_ready;

    // Selecting the granted channel's data with a one-hot mux avoids a
    // variable-width part-select.
    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_push_data = in_data[i*DW +: DW];
            end
        end
    end

    // Pointers, occupancy and arbitration history. The round-robin pointer
    // moves only on a real grant. It therefore holds across a full FIFO or a
    // capture_en gap, and fairness resumes where it stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_last_grant <= CW'(NUM_CH - 1);
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_last_grant <= w_grant_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage has no reset. Stale entries are never visible because the
    // outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_ch[r_wr_ptr]   <= w_grant_idx;
        end
    end

    // The tc pad pipeline is independent of the FIFO. Only reset touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc_d1 <= 1'b0;
            r_tc_d2 <= 1'b0;
            r_tc_oe <= 1'b0;
        end else begin
            r_tc_d1 <= tc_in;
            r_tc_d2 <= r_tc_d1;
            r_tc_oe <= capture_en;
        end
    end

    // The head entry falls straight through. Data and tag read as zero while
    // the FIFO is empty, so nothing undefined leaves the block after reset.
    assign out_valid  = w_not_empty;
    assign out_data   = w_not_empty ? r_mem_data[r_rd_ptr] : '0;
    assign out_ch     = w_not_empty ? r_mem_ch[r_rd_ptr]   : '0;
    assign fifo_level = r_level;
    assign tc_out     = r_tc_d2;
    assign tc_oe      = r_tc_oe;

endmodule

// File: tb/tb_design_c_hub.sv
// -----------------------------------------------------------------------------
// tb_design_c_hub
// Scoreboard bench for design_c_hub. The stimulus side predicts each grant
// from the round-robin rule. When a transfer happens it queues the expected
// {channel, data} entry. An independent monitor compares the DUT head,
// occupancy and tc pins against that queue every cycle.
// -----------------------------------------------------------------------------
module tb_design_c_hub;
    import design_c_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int DEPTH  = 8;
    localparam int CW     = 2;
    localparam int AW     = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 capture_en;
    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH*DW-1:0] in_data;
    logic [NUM_CH-1:0]    in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_ready;
    logic [AW:0]          fifo_level;
    logic                 tc_in;
    logic                 tc_out;
    logic                 tc_oe;

    design_c_hub #(
        .NUM_CH (NUM_CH),
        .DW     (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .tc_in      (tc_in),
        .tc_out     (tc_out),
        .tc_oe      (tc_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int data;
    } entry_t;

    entry_t sbq[$];
    int     mLast;
    bit     gValid;
    int     gCh;
    int     gData;
    bit     tcH1;
    bit     tcH2;
    bit     oeM;
    bit     monEn = 1'b0;
    int     total = 0;
    int     bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setData(input int ch, input int val);
        in_data[ch*DW +: DW] = DW'(val);
    endtask

    // Reference grant: scan the channels after the last winner, but only
    // when capture is on, reset is off and the model queue has room.
    task automatic checkGrant();
        logic [NUM_CH-1:0] expMask;
        gValid = 1'b0;
        gCh    = 0;
        gData  = 0;
        if (!rst && capture_en && sbq.size() < DEPTH) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (mLast + k) % NUM_CH;
                if (in_valid[c]) begin
                    gValid = 1'b1;
                    gCh    = c;
                    gData  = int'(in_data[c*DW +: DW]);
                    break;
                end
            end
        end
        expMask = gValid ? NUM_CH'(1 << gCh) : '0;
        check("in_ready", 32'(in_ready), 32'(expMask));
    endtask

    // The model's view of what the clock edge does.
    task automatic modelEdge();
        if (rst) begin
            sbq.delete();
            mLast = NUM_CH - 1;
            tcH1  = 1'b0;
            tcH2  = 1'b0;
            oeM   = 1'b0;
            monEn = 1'b1;
        end else begin
            if (gValid) begin
                sbq.push_back('{gCh, gData});
                mLast = gCh;
            end
            tcH2 = tcH1;
            tcH1 = tc_in;
            oeM  = capture_en;
        end
    endtask

    // Call this with the inputs already driven at posedge+1. It checks the
    // grant, advances the model on the edge, and returns at posedge+1.
    task automatic applyStimulus();
        #2;
        checkGrant();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput();
        check("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
        check("fifo_level", 32'(fifo_level), 32'(sbq.size()));
        check("tc_out", 32'(tc_out), 32'(tcH2));
        check("tc_oe", 32'(tc_oe), 32'(oeM));
        if (sbq.size() != 0) begin
            check("out_ch", 32'(out_ch), 32'(sbq[0].ch));
            check("out_data", 32'(out_data), 32'(sbq[0].data));
            if (out_ready) begin
                void'(sbq.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            checkOutput();
        end
    end

    task automatic drain();
        capture_en = 1'b1;
        in_valid   = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus();
        end
    endtask

    initial begin
        int cnt;
        rst        = 1'b1;
        capture_en = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        tc_in      = 1'b0;
        mLast      = NUM_CH - 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
        end
        rst = 1'b0;

        // All channels streaming, downstream always ready. Includes a
        // one-cycle tc pulse.
        $display("[TB] phase: round-robin streaming");
        capture_en = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = '1;
            in_data  = {$urandom(), $urandom()};
            tc_in    = (i == 10);
            applyStimulus();
        end
        tc_in = 1'b0;
        drain();

        // Channel 2 alone into a blocked FIFO, then released.
        $display("[TB] phase: fill to full and release");
        cnt       = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (i == 12) begin
                out_ready = 1'b1;
            end
            in_valid = (cnt < 10) ? 4'b0100 : 4'b0000;
            setData(2, 'h00A0 + cnt);
            applyStimulus();
            if (gValid) begin
                cnt++;
            end
        end
        drain();

        // Fill with ch1, then ch1+ch3 compete while full. One pop must hand
        // the freed slot to ch3.
        $display("[TB] phase: fairness across full");
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_valid  = (i < 9) ? 4'b0010 : 4'b1010;
            out_ready = (i == 11);
            in_data   = {$urandom(), $urandom()};
            applyStimulus();
        end
        drain();

        // Queue five entries, then drop capture_en while draining.
        $display("[TB] phase: capture_en drop");
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            capture_en = (i < 5);
            out_ready  = (i >= 5);
            in_valid   = '1;
            in_data    = {$urandom(), $urandom()};
            applyStimulus();
        end
        drain();

        // Reset with six entries queued.
        $display("[TB] phase: mid-stream reset");
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            rst       = (i == 6);
            out_ready = (i > 6);
            in_valid  = '1;
            in_data   = {$urandom(), $urandom()};
            applyStimulus();
        end
        rst = 1'b0;
        drain();

        // Randomized traffic with occasional reset.
        $display("[TB] phase: random traffic");
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            capture_en = ($urandom_range(0, 7) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_valid   = NUM_CH'($urandom());
            in_data    = {$urandom(), $urandom()};
            tc_in      = 1'($urandom());
            applyStimulus();
        end
        rst = 1'b0;
        drain();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/design_c_hub.md
Name: design_c_hub

Overview:
- Parametrised successor to the fixed-port block C shell.
- Gathers NUM_CH source channels (nets arriving from blocks A and B) into a single tagged output stream.
- Uses fair round-robin arbitration and an internal first-word-fall-through (FWFT) FIFO.
- Carries the test-control (tc) path as a registered, synthesizable out/oe pair instead of an inout. The inout is resolved at the pad level.

Parameters:
- NUM_CH, 4: number of input channels, 2..16.
- DW, 16: data width per channel.
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- CW, $clog2(NUM_CH): localparam, width of the channel tag.
- AW, $clog2(DEPTH): localparam, FIFO pointer width.

Ports:
- clk  input  1  single block clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- capture_en  input  1  when 0, no channel is granted.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*DW  channel i occupies bits [i*DW +: DW].
- in_ready  output  NUM_CH  one-hot-or-zero grant; channel i is accepted when in_valid[i] and in_ready[i] are both 1.
- out_valid  output  1  FIFO non-empty.
- out_data  output  DW  head entry data.
- out_ch  output  CW  source channel of the head entry.
- out_ready  input  1  downstream accepts.
- fifo_level  output  AW+1  current occupancy, 0..DEPTH.
- tc_in  input  1  test-control input.
- tc_out  output  1  tc_in delayed 2 cycles.
- tc_oe  output  1  output-enable for the tc pad; registered copy of capture_en.

Behaviour:
- Reset (clk edge with rst=1):
  - FIFO empty, fifo_level=0, out_valid=0.
  - out_data and out_ch are don't-care but must be driven; implement as zero.
  - Round-robin pointer last_grant=NUM_CH-1, so channel 0 has first priority.
  - tc pipeline cleared: tc_out=0, tc_oe=0.
  - in_ready=0 during reset.
  - Reset mid-operation discards all FIFO contents and any in-flight grant.
- Arbitration (combinational, same cycle):
  - Grant is possible when capture_en=1, fifo_level<DEPTH and not in reset.
  - Search indices last_grant+1, last_grant+2, ... modulo NUM_CH; grant the first channel with in_valid=1.
  - in_ready is one-hot on the granted channel, otherwise all zero.
  - in_ready must not depend on out_ready: no full-and-pop bypass.
- Push: on a granted transfer at edge k:
  - write {i, in_data[i]} at the write pointer;
  - set last_grant=i;
  - leave last_grant unchanged when there is no grant.
- Output:
  - FWFT: out_valid = (fifo_level != 0); out_data/out_ch reflect the head entry.
  - Latency: an accept at edge k into an empty FIFO makes out_valid=1 after edge k. Data is visible 1 cycle after the transfer.
- Pop: out_valid=1 and out_ready=1 advances the read pointer.
- Pointers:
  - Read and write pointers are AW bits and wrap naturally.
  - fifo_level is a separate AW+1 counter.
  - Simultaneous push and pop leaves fifo_level unchanged.
- Full: fifo_level==DEPTH drives all in_ready=0. last_grant holds, so fairness resumes where it stopped.
- Empty: out_valid=0; out_ready is ignored and the read pointer does not move.
- Stability: out_data and out_ch must hold while out_valid=1 and out_ready=0.
- tc path: tc_out = tc_in through 2 flops; tc_oe = capture_en through 1 flop. Both are unaffected by FIFO state.
- capture_en is deasserted mid-stream: grants stop in the same cycle; the FIFO continues to drain normally.

Decomposition:
- Package design_c_pkg:
  - default constants NUM_CH_DEF, DW_DEF, DEPTH_DEF;
  - function rr_next(req, last, n), shared with other hub variants.
- Sub-module design_c_rr_arb (param N): req, last_grant in; one-hot grant and grant index out; purely combinational.
- The FIFO stays inline, as two pointers, a level counter and a register array.

Test Plan:
- Reset then all 4 channels valid continuously, out_ready=1:
  - grants cycle ch0,1,2,3,0...;
  - out_ch sequence 0,1,2,3 starting 1 cycle after the first accept;
  - fifo_level stays 1.
- out_ready=0, ch2 only valid with data 0x00A0..0x00A9:
  - exactly 8 accepts, then in_ready=0 and fifo_level=8;
  - release out_ready: data pops in order 0x00A0..0x00A7, then ch2 resumes with 0x00A8.
- Full FIFO with ch1 and ch3 valid; last grant was ch1; pop one entry:
  - next grant goes to ch3 (pointer held across the full condition), not ch1.
- capture_en dropped with 5 entries queued:
  - in_ready=0 the same cycle;
  - 5 pops still delivered;
  - tc_oe falls 1 cycle later.
- rst asserted for 1 cycle with fifo_level=6:
  - next cycle out_valid=0, fifo_level=0;
  - first grant after reset goes to ch0.
- tc_in pulse of 1 cycle at cycle 10: tc_out high at cycle 12 only, independent of FIFO traffic.
